// File: rtl/mem_port_sequencer.sv
// Phase sequencer sharing instruction/data RAM between the stream loader, the processor and the dumper.
// Owns all RAM muxing, the processor start pulse and the registered dump stream.
module mem_port_sequencer #(
    parameter int unsigned INS_WIDTH           = 8,
    parameter int unsigned DATA_MEM_WIDTH      = 12,
    parameter int unsigned INS_MEM_ADDR_WIDTH  = 8,
    parameter int unsigned DATA_MEM_ADDR_WIDTH = 12,
    parameter int unsigned INS_COUNT           = 256,
    parameter int unsigned DATA_COUNT          = 4096,
    parameter int unsigned DUMP_BASE           = 0,
    parameter int unsigned DUMP_COUNT          = 16
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic                           startN,
    input  logic                           ld_valid,
    input  logic [DATA_MEM_WIDTH-1:0]      ld_data,
    output logic                           ld_ready,
    output logic                           proc_startN,
    input  logic                           proc_done,
    input  logic [INS_MEM_ADDR_WIDTH-1:0]  proc_insAddr,
    input  logic [DATA_MEM_ADDR_WIDTH-1:0] proc_dataAddr,
    input  logic [DATA_MEM_WIDTH-1:0]      proc_dataOut,
    input  logic                           proc_wrEn,
    output logic [INS_MEM_ADDR_WIDTH-1:0]  insMemAddr,
    output logic                           insMemWrEn,
    output logic [INS_WIDTH-1:0]           insMemIn,
    output logic [DATA_MEM_ADDR_WIDTH-1:0] dataMemAddr,
    output logic                           dataMemWrEn,
    output logic [DATA_MEM_WIDTH-1:0]      dataMemIn,
    input  logic [DATA_MEM_WIDTH-1:0]      dataMemOut,
    output logic [DATA_MEM_WIDTH-1:0]      tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic [2:0]                     state,
    output logic                           done
);
    localparam int unsigned IW      = INS_WIDTH;
    localparam int unsigned DMW     = DATA_MEM_WIDTH;
    localparam int unsigned IAW     = INS_MEM_ADDR_WIDTH;
    localparam int unsigned DAW     = DATA_MEM_ADDR_WIDTH;
    localparam int unsigned MAX_LD  = (INS_COUNT > DATA_COUNT) ? INS_COUNT : DATA_COUNT;
    localparam int unsigned MAX_CNT = (MAX_LD > DUMP_COUNT) ? MAX_LD : DUMP_COUNT;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;

    localparam logic [CNT_W-1:0] INS_LAST  = CNT_W'(INS_COUNT - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_COUNT - 1);
    localparam logic [CNT_W-1:0] DUMP_LAST = CNT_W'(DUMP_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_INS  = 3'd1,
        S_LOAD_DATA = 3'd2,
        S_EXEC      = 3'd4,
        S_DUMP      = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        D_RD   = 2'd0,
        D_LAT  = 2'd1,
        D_SEND = 2'd2
    } dphase_t;

    state_t           r_state;
    dphase_t          r_dphase;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tx_valid;
    logic [DMW-1:0]   r_tx_data;
    logic             r_proc_startN;
    logic             r_done;

    state_t           w_state_nxt;
    dphase_t          w_dphase_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_tx_valid_nxt;
    logic             w_tx_load;
    logic [DAW-1:0]   w_dump_addr;

    // Dump address wraps modulo the data RAM size.
    assign w_dump_addr = DAW'(DUMP_BASE) + DAW'(r_cnt);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state       <= S_IDLE;
            r_dphase      <= D_RD;
            r_cnt         <= '0;
            r_tx_valid    <= 1'b0;
            r_tx_data     <= '0;
            r_proc_startN <= 1'b1;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_dphase      <= w_dphase_nxt;
            r_cnt         <= w_cnt_nxt;
            r_tx_valid    <= w_tx_valid_nxt;
            r_proc_startN <= !((r_state != S_EXEC) && (w_state_nxt == S_EXEC));
            r_done        <= (w_state_nxt == S_FINISH);
            if (w_tx_load) begin
                r_tx_data <= dataMemOut;
            end
        end
    end

    // Next-state and counter/dump-phase control.
    always_comb begin
        w_state_nxt    = r_state;
        w_dphase_nxt   = r_dphase;
        w_cnt_nxt      = r_cnt;
        w_tx_valid_nxt = r_tx_valid;
        w_tx_load      = 1'b0;
        case (r_state)
            S_IDLE, S_FINISH: begin
                if (!startN) begin
                    w_state_nxt = S_LOAD_INS;
                    w_cnt_nxt   = '0;
                end
            end
            S_LOAD_INS: begin
                if (ld_valid) begin
                    if (r_cnt == INS_LAST) begin
                        w_state_nxt = S_LOAD_DATA;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_LOAD_DATA: begin
                if (ld_valid) begin
                    if (r_cnt == DATA_LAST) begin
                        w_state_nxt = S_EXEC;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_EXEC: begin
                if (proc_done) begin
                    w_state_nxt  = S_DUMP;
                    w_dphase_nxt = D_RD;
                    w_cnt_nxt    = '0;
                end
            end
            S_DUMP: begin
                case (r_dphase)
                    D_RD:  w_dphase_nxt = D_LAT;
                    D_LAT: begin
                        w_dphase_nxt   = D_SEND;
                        w_tx_load      = 1'b1;
                        w_tx_valid_nxt = 1'b1;
                    end
                    D_SEND: begin
                        if (tx_ready) begin
                            w_tx_valid_nxt = 1'b0;
                            w_dphase_nxt   = D_RD;
                            if (r_cnt == DUMP_LAST) begin
                                w_state_nxt = S_FINISH;
                                w_cnt_nxt   = '0;
                            end else begin
                                w_cnt_nxt = r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: w_dphase_nxt = D_RD;
                endcase
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // RAM port muxing; everything is held at zero while reset is asserted.
    always_comb begin
        ld_ready    = 1'b0;
        insMemAddr  = '0;
        insMemWrEn  = 1'b0;
        insMemIn    = '0;
        dataMemAddr = '0;
        dataMemWrEn = 1'b0;
        dataMemIn   = '0;
        if (rstN) begin
            case (r_state)
                S_LOAD_INS: begin
                    ld_ready   = 1'b1;
                    insMemAddr = IAW'(r_cnt);
                    if (ld_valid) begin
                        insMemWrEn = 1'b1;
                        insMemIn   = ld_data[IW-1:0];
                    end
                end
                S_LOAD_DATA: begin
                    ld_ready    = 1'b1;
                    dataMemAddr = DAW'(r_cnt);
                    if (ld_valid) begin
                        dataMemWrEn = 1'b1;
                        dataMemIn   = ld_data;
                    end
                end
                S_EXEC: begin
                    insMemAddr  = proc_insAddr;
                    dataMemAddr = proc_dataAddr;
                    dataMemWrEn = proc_wrEn;
                    dataMemIn   = proc_dataOut;
                end
                S_DUMP:  dataMemAddr = w_dump_addr;
                default: ;
            endcase
        end
    end

    assign state       = r_state;
    assign done        = r_done;
    assign tx_valid    = r_tx_valid;
    assign tx_data     = r_tx_data;
    assign proc_startN = r_proc_startN;

endmodule
